// File: rtl/chess_pkg.sv
// Shared piece codes, FSM encoding, move-history entry and standard opening layout.
package chess_pkg;

    localparam logic [3:0] EMPTY    = 4'h0;
    localparam logic [3:0] W_PAWN   = 4'h1;
    localparam logic [3:0] W_BISHOP = 4'h2;
    localparam logic [3:0] W_KNIGHT = 4'h3;
    localparam logic [3:0] W_ROOK   = 4'h4;
    localparam logic [3:0] W_QUEEN  = 4'h5;
    localparam logic [3:0] W_KING   = 4'h6;
    localparam logic [3:0] B_PAWN   = 4'h7;
    localparam logic [3:0] B_BISHOP = 4'h8;
    localparam logic [3:0] B_KNIGHT = 4'h9;
    localparam logic [3:0] B_ROOK   = 4'hA;
    localparam logic [3:0] B_QUEEN  = 4'hB;
    localparam logic [3:0] B_KING   = 4'hC;
    localparam logic [3:0] HINT     = 4'hD;

    // Field widths of move_entry_t for the default 8x8 board with 4-bit codes.
    localparam int DEF_POS_W  = 6;
    localparam int DEF_CODE_W = 4;

    typedef enum logic {IDLE, HOLD} fsm_t;

    typedef struct packed {
        logic [DEF_POS_W-1:0]  from_pos;
        logic [DEF_POS_W-1:0]  to_pos;
        logic [DEF_CODE_W-1:0] piece;
        logic [DEF_CODE_W-1:0] capt;
    } move_entry_t;

    // Standard layout for an 8x8 board; black codes are white codes offset by 6.
    function automatic logic [3:0] std_code(input int row, input int col);
        logic [3:0] back;
        case (col)
            0, 7:    back = W_ROOK;
            1, 6:    back = W_KNIGHT;
            2, 5:    back = W_BISHOP;
            3:       back = W_QUEEN;
            default: back = W_KING;
        endcase
        case (row)
            0:       return back + 4'd6;
            1:       return B_PAWN;
            6:       return W_PAWN;
            7:       return back;
            default: return EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/chess_move_stack.sv
// Circular LIFO of committed moves. A push into a full stack overwrites the
// oldest entry; the count saturates at DEPTH so undo depth never exceeds it.
module chess_move_stack
    import chess_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = move_entry_t
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  entry_t push_data,
    output entry_t top_data,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  top_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    assign top_ptr  = wr_ptr - 1'b1;
    assign top_data = mem[top_ptr];

    // Next occupancy: saturate on push, floor at zero on pop.
    always_comb begin
        count_nxt = count;
        if (push) begin
            if (count != CNT_W'(DEPTH)) count_nxt = count + 1'b1;
        end else if (pop && count != '0) begin
            count_nxt = count - 1'b1;
        end
    end

    // Entry storage; slot at wr_ptr is the oldest entry once the stack is full.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointer, count and registered empty flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
        end else begin
            if (push)                        wr_ptr <= wr_ptr + 1'b1;
            else if (pop && count != '0)     wr_ptr <= wr_ptr - 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/chess_board_ctrl.sv
// Board store and pick/place/cancel/undo controller with a hinted render port.
module chess_board_ctrl
    import chess_pkg::*;
#(
    parameter int              BOARD_W    = 8,
    parameter int              BOARD_H    = 8,
    parameter int              CODE_W     = 4,
    parameter int              HIST_DEPTH = 16,
    parameter bit              INIT_STD   = 1'b1,
    parameter logic [CODE_W-1:0] HINT_CODE = 4'hD,
    localparam int             POS_W      = $clog2(BOARD_H) + $clog2(BOARD_W),
    localparam int             N          = BOARD_W * BOARD_H
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [POS_W-1:0]    sel_pos,
    input  logic                pick,
    input  logic                place,
    input  logic                cancel,
    input  logic                undo,
    input  logic [N-1:0]        possible_moves,
    input  logic [POS_W-1:0]    rd_pos,
    output logic [CODE_W-1:0]   rd_code,
    output logic [N*CODE_W-1:0] board_flat,
    output logic                held_valid,
    output logic [CODE_W-1:0]   held_code,
    output logic [POS_W-1:0]    from_pos,
    output logic                move_done,
    output logic [CODE_W-1:0]   captured_code,
    output logic                illegal,
    output logic                hist_empty
);

    // The standard layout only makes sense on an 8x8 board.
    localparam bit USE_STD = INIT_STD && (BOARD_W == 8) && (BOARD_H == 8);

    typedef struct packed {
        logic [POS_W-1:0]  from_pos;
        logic [POS_W-1:0]  to_pos;
        logic [CODE_W-1:0] piece;
        logic [CODE_W-1:0] capt;
    } entry_t;

    fsm_t              state;
    logic [CODE_W-1:0] board [N];
    logic [CODE_W-1:0] sel_code;
    logic              pick_ok;
    logic              undo_ok;
    logic              place_self;
    logic              place_legal;
    logic              place_bad;
    logic              cancel_ok;
    entry_t            push_entry;
    entry_t            top_entry;

    // Command decode: pick beats undo in IDLE, place beats cancel in HOLD.
    always_comb begin
        sel_code    = board[sel_pos];
        pick_ok     = (state == IDLE) && pick && (sel_code != '0);
        undo_ok     = (state == IDLE) && !pick && undo && !hist_empty;
        place_self  = (state == HOLD) && place && (sel_pos == from_pos);
        place_legal = (state == HOLD) && place && !place_self && possible_moves[sel_pos];
        place_bad   = (state == HOLD) && place && !place_self && !possible_moves[sel_pos];
        cancel_ok   = (state == HOLD) && !place && cancel;
        push_entry  = '{from_pos: from_pos, to_pos: sel_pos, piece: held_code, capt: sel_code};
    end

    chess_move_stack #(
        .DEPTH   (HIST_DEPTH),
        .entry_t (entry_t)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (place_legal),
        .pop       (undo_ok),
        .push_data (push_entry),
        .top_data  (top_entry),
        .empty     (hist_empty)
    );

    // Board contents, move FSM and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < N; p++)
                board[p] <= USE_STD ? CODE_W'(std_code(p / BOARD_W, p % BOARD_W)) : '0;
            state         <= IDLE;
            held_valid    <= 1'b0;
            held_code     <= '0;
            from_pos      <= '0;
            move_done     <= 1'b0;
            captured_code <= '0;
            illegal       <= 1'b0;
        end else begin
            move_done <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        board[sel_pos] <= '0;
                        held_code      <= sel_code;
                        held_valid     <= 1'b1;
                        from_pos       <= sel_pos;
                        state          <= HOLD;
                    end else if (undo_ok) begin
                        board[top_entry.from_pos] <= top_entry.piece;
                        board[top_entry.to_pos]   <= top_entry.capt;
                    end
                end
                HOLD: begin
                    if (place_self || cancel_ok) begin
                        board[from_pos] <= held_code;
                        held_valid      <= 1'b0;
                        held_code       <= '0;
                        state           <= IDLE;
                    end else if (place_legal) begin
                        board[sel_pos] <= held_code;
                        captured_code  <= sel_code;
                        move_done      <= 1'b1;
                        held_valid     <= 1'b0;
                        held_code      <= '0;
                        state          <= IDLE;
                    end else if (place_bad) begin
                        illegal <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Render read port: legal empty targets show the hint code while a piece is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_code <= '0;
        end else if (board[rd_pos] == '0 && held_valid && possible_moves[rd_pos]) begin
            rd_code <= HINT_CODE;
        end else begin
            rd_code <= board[rd_pos];
        end
    end

    // Flattened view of the whole board.
    always_comb begin
        board_flat = '0;
        for (int p = 0; p < N; p++)
            board_flat[p*CODE_W +: CODE_W] = board[p];
    end

endmodule
